// File: rtl/id_stage_top.sv
// RV32I decode stage: instruction decode, 32x32 register file with WB write-through,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_pc_plus4,
  input  logic [31:0] if_id_instr,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [31:0] id_ex_pc_plus4,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_ctrl,
  output logic        id_ex_alu_src,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_to_reg,
  output logic        id_ex_branch
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd_field;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_writes_rd;
  logic        w_alu_src;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_branch;
  logic [3:0]  w_alu_ctrl;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_reg_write;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_stall;
  logic [31:0] w_rf [0:31];

  assign w_opcode   = if_id_instr[6:0];
  assign w_funct3   = if_id_instr[14:12];
  assign w_rd_field = if_id_instr[11:7];

  function automatic logic [3:0] f_alu_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    w_rs1_used   = 1'b0;
    w_rs2_used   = 1'b0;
    w_writes_rd  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_alu_ctrl   = ALU_ADD;
    w_imm        = '0;
    case (w_opcode)
      OP_R: begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
        w_writes_rd = 1'b1;
        w_alu_ctrl  = f_alu_op(w_funct3, if_id_instr[30]);
      end
      OP_I: begin
        // instr[30] only distinguishes srai; addi's bit 30 belongs to its immediate
        w_rs1_used  = 1'b1;
        w_writes_rd = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = f_alu_op(w_funct3, if_id_instr[30] && (w_funct3 == 3'b101));
        w_imm       = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_LW: begin
        w_rs1_used   = 1'b1;
        w_writes_rd  = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_imm        = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_SW: begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm       = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
      end
      OP_BEQ: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_branch   = 1'b1;
        w_alu_ctrl = ALU_SUB;
        w_imm      = {{20{if_id_instr[31]}}, if_id_instr[7], if_id_instr[30:25],
                      if_id_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        w_writes_rd = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = ALU_PASSB;
        w_imm       = {if_id_instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Unused source indices are zeroed so they can never match a hazard or forward
  assign w_rs1       = w_rs1_used ? if_id_instr[19:15] : 5'd0;
  assign w_rs2       = w_rs2_used ? if_id_instr[24:20] : 5'd0;
  assign w_reg_write = w_writes_rd && (w_rd_field != 5'd0);
  assign w_rd        = w_reg_write ? w_rd_field : 5'd0;

  assign w_rf[0] = '0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    logic [31:0] r_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_q <= '0;
      else if (wb_reg_write && (wb_rd == 5'(gi)))
        r_q <= wb_data;
    end
    assign w_rf[gi] = r_q;
  end

  assign w_rs1_data = ((w_rs1 != 5'd0) && wb_reg_write && (wb_rd == w_rs1)) ? wb_data : w_rf[w_rs1];
  assign w_rs2_data = ((w_rs2 != 5'd0) && wb_reg_write && (wb_rd == w_rs2)) ? wb_data : w_rf[w_rs2];

  assign w_stall = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((id_ex_rd == w_rs1) || (id_ex_rd == w_rs2));
  assign pc_write    = ~w_stall;
  assign if_id_write = ~w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || w_stall) begin
      id_ex_pc_plus4   <= '0;
      id_ex_rs1_data   <= '0;
      id_ex_rs2_data   <= '0;
      id_ex_imm        <= '0;
      id_ex_rs1        <= '0;
      id_ex_rs2        <= '0;
      id_ex_rd         <= '0;
      id_ex_alu_ctrl   <= '0;
      id_ex_alu_src    <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_branch     <= 1'b0;
    end else begin
      id_ex_pc_plus4   <= if_id_pc_plus4;
      id_ex_rs1_data   <= w_rs1_data;
      id_ex_rs2_data   <= w_rs2_data;
      id_ex_imm        <= w_imm;
      id_ex_rs1        <= w_rs1;
      id_ex_rs2        <= w_rs2;
      id_ex_rd         <= w_rd;
      id_ex_alu_ctrl   <= w_alu_ctrl;
      id_ex_alu_src    <= w_alu_src;
      id_ex_mem_read   <= w_mem_read;
      id_ex_mem_write  <= w_mem_write;
      id_ex_reg_write  <= w_reg_write;
      id_ex_mem_to_reg <= w_mem_to_reg;
      id_ex_branch     <= w_branch;
    end
  end

endmodule
